// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder for the M stage.
// Holds the pipeline with MemStallM while a WAIT_STATES counter runs, commits
// byte-masked stores, and returns the full aligned word with a MemDoneM strobe.
// Optional feature macro: DMEM_ERR_EN (out-of-range address error, MemErrM port).
`timescale 1ns/1ps

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [3:0]  ByteMaskM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        MemDoneM
`ifdef DMEM_ERR_EN
  ,
  output logic        MemErrM
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               commit;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_wr;
  logic [3:0]         lat_mask;
  logic [31:0]        lat_data;
  logic               lat_err;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        cur_word;
  logic [31:0]        merged;

`ifdef DMEM_ERR_EN
  logic               addr_hi;
  logic               unused_addr;
  assign addr_hi     = |AddrM[31:IDX_W+2];
  assign unused_addr = ^AddrM[1:0];
`else
  logic               unused_addr;
  assign unused_addr = ^{AddrM[31:IDX_W+2], AddrM[1:0]};
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (MemReqM) state_next = S_WAIT;
      S_WAIT: if (cnt == '0) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs and internal strobes; stall is forced low during reset
  always_comb begin
    MemStallM = 1'b0;
    MemDoneM  = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        MemStallM = MemReqM && !reset;
        accept    = MemReqM;
      end
      S_WAIT: begin
        MemStallM = 1'b1;
        commit    = (cnt == '0);
      end
      S_RESP: MemDoneM = 1'b1;
      default: ;
    endcase
  end

  // Request latch, wait counter, read register and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wr    <= 1'b0;
      lat_mask  <= '0;
      lat_data  <= '0;
      ReadDataM <= '0;
`ifdef DMEM_ERR_EN
      lat_err   <= 1'b0;
      MemErrM   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt      <= CNT_W'(WAIT_STATES);
        lat_idx  <= AddrM[IDX_W+1:2];
        lat_wr   <= MemWriteM;
        lat_mask <= ByteMaskM;
        lat_data <= WriteDataM;
`ifdef DMEM_ERR_EN
        lat_err  <= addr_hi;
`endif
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        if (lat_err)     ReadDataM <= '0;
        else if (lat_wr) ReadDataM <= merged;
        else             ReadDataM <= cur_word;
`ifdef DMEM_ERR_EN
        if (lat_err) MemErrM <= 1'b1;
`endif
      end
    end
  end

`ifndef DMEM_ERR_EN
  assign lat_err = 1'b0;
`endif

  // Post-write view of the addressed word
  assign cur_word = mem[lat_idx];
  always_comb begin
    merged = cur_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lat_mask[i]) merged[8*i +: 8] = lat_data[8*i +: 8];
    end
  end

  // Storage array: not reset; only masked lanes of a committing store change
  always_ff @(posedge clk) begin
    if (commit && lat_wr && !lat_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lat_mask[i]) mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: randomized loads/stores against a word-level
// reference memory, byte-lane merging, latency sweep, mid-access reset and
// (with DMEM_ERR_EN) the out-of-range error behaviour.
`timescale 1ns/1ps

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, req_c;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        stall_a, stall_b, stall_c;
  logic        done_a, done_b, done_c;
`ifdef DMEM_ERR_EN
  logic        err_a, err_b, err_c;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
    .clk(clk), .reset(reset), .MemReqM(req_a), .MemWriteM(wr), .ByteMaskM(mask),
    .AddrM(addr), .WriteDataM(wdata), .ReadDataM(rdata_a), .MemStallM(stall_a),
    .MemDoneM(done_a)
`ifdef DMEM_ERR_EN
    , .MemErrM(err_a)
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .MemReqM(req_b), .MemWriteM(wr), .ByteMaskM(mask),
    .AddrM(addr), .WriteDataM(wdata), .ReadDataM(rdata_b), .MemStallM(stall_b),
    .MemDoneM(done_b)
`ifdef DMEM_ERR_EN
    , .MemErrM(err_b)
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(15)) u_dut15 (
    .clk(clk), .reset(reset), .MemReqM(req_c), .MemWriteM(wr), .ByteMaskM(mask),
    .AddrM(addr), .WriteDataM(wdata), .ReadDataM(rdata_c), .MemStallM(stall_c),
    .MemDoneM(done_c)
`ifdef DMEM_ERR_EN
    , .MemErrM(err_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int which, input logic v);
    case (which)
      0: req_a = v;
      1: req_b = v;
      default: req_c = v;
    endcase
  endtask

  task automatic probe(input int which, output logic st, output logic dn, output logic [31:0] r);
    case (which)
      0: begin st = stall_a; dn = done_a; r = rdata_a; end
      1: begin st = stall_b; dn = done_b; r = rdata_b; end
      default: begin st = stall_c; dn = done_c; r = rdata_c; end
    endcase
  endtask

  // Word-level expectation: the model word with masked lanes replaced
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One access; inputs are scrambled right after acceptance to prove they are latched
  task automatic access(input int which, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    int   stalls;
    int   ws;
    bit   got;
    logic st, dn;
    logic [31:0] r;
    ws = (which == 0) ? 2 : (which == 1) ? 0 : 15;
    stalls = 0;
    got = 1'b0;
    rd = '0;
    @(negedge clk);
    wr = w; mask = m; addr = a; wdata = d;
    set_req(which, 1'b1);
    for (int c = 0; c < 40; c++) begin
      #1;
      probe(which, st, dn, r);
      if (dn) begin
        got = 1'b1;
        rd = r;
        chk("stall_in_resp", 32'(st), 32'd0);
        break;
      end
      if (st) stalls++;
      @(posedge clk);
      #1;
      if (c == 0) begin
        set_req(which, 1'b0);
        wr = $urandom_range(0, 1);
        mask = 4'($urandom);
        addr = $urandom;
        wdata = $urandom;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(ws + 2));
    @(negedge clk);
    #1;
    probe(which, st, dn, r);
    chk("done_single", 32'(dn), 32'd0);
  endtask

  // Access on the main DUT with the model updated and the returned word checked
  task automatic model_access(input logic w, input logic [3:0] m, input logic [31:0] a,
                              input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    int idx;
    idx = int'(a[11:2]);
    if (w) begin
      exp = lane_merge(model.exists(idx) ? model[idx] : 32'h0, d, m);
      model[idx] = exp;
    end else begin
      exp = model[idx];
    end
    access(0, w, m, a, d, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int pool [8];
    logic st, dn;
    logic [31:0] r;

    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    wr = 1'b0; mask = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
`ifdef DMEM_ERR_EN
    chk("rst_err", 32'(err_a), 32'd0);
`endif

    // Basic store then load
    model_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "store_10");
    model_access(1'b0, 4'h0, 32'h10, 32'h0, "load_10");
    chk("load_10_const", model[4], 32'hDEADBEEF);

    // Byte lanes
    model_access(1'b1, 4'hF, 32'h20, 32'h11223344, "lane_init");
    model_access(1'b1, 4'h8, 32'h20, 32'hAA000000, "lane_hi");
    model_access(1'b1, 4'h2, 32'h22, 32'h0000BB00, "lane_b1");
    access(0, 1'b0, 4'h0, 32'h21, 32'h0, rd);
    chk("lane_load", rd, 32'hAA22BB44);
    model_access(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, "mask_zero");

    // Randomized traffic over a pool of initialised words
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(32, 1023);
      model_access(1'b1, 4'hF, 32'(pool[i]) << 2, $urandom, "rand_init");
    end
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = (32'(pool[$urandom_range(0, 7)]) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        model_access(1'b1, 4'($urandom), a, $urandom, "rand_store");
      else
        model_access(1'b0, 4'($urandom), a, $urandom, "rand_load");
    end

    // Reset one cycle before commit: store abandoned, outputs cleared at once
    model_access(1'b1, 4'hF, 32'h40, 32'h0BADF00D, "pre_reset");
    @(negedge clk);
    wr = 1'b1; mask = 4'hF; addr = 32'h40; wdata = 32'h55555555; req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_rdata", rdata_a, 32'h0);
    chk("midrst_stall", 32'(stall_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_access(1'b0, 4'h0, 32'h40, 32'h0, "midrst_keep");

    // Latency sweep at WAIT_STATES 0 and 15
    access(1, 1'b1, 4'hF, 32'h80, 32'h12345678, rd);
    chk("ws0_store", rd, 32'h12345678);
    access(1, 1'b0, 4'h0, 32'h80, 32'h0, rd);
    chk("ws0_load", rd, 32'h12345678);
    access(2, 1'b1, 4'hF, 32'h84, 32'h9ABCDEF0, rd);
    chk("ws15_store", rd, 32'h9ABCDEF0);
    access(2, 1'b0, 4'h0, 32'h84, 32'h0, rd);
    chk("ws15_load", rd, 32'h9ABCDEF0);

    // Out-of-range address: error with the feature, wrap without it
    model_access(1'b1, 4'hF, 32'h0, 32'h01020304, "word0_init");
    access(0, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, rd);
`ifdef DMEM_ERR_EN
    chk("oor_store_rd", rd, 32'h0);
    chk("oor_err", 32'(err_a), 32'd1);
    access(0, 1'b0, 4'h0, 32'h1000, 32'h0, rd);
    chk("oor_load_zero", rd, 32'h0);
    model_access(1'b0, 4'h0, 32'h0, 32'h0, "oor_word0_kept");
    chk("err_sticky", 32'(err_a), 32'd1);
`else
    chk("wrap_store_rd", rd, 32'hCAFEF00D);
    model[0] = 32'hCAFEF00D;
    model_access(1'b0, 4'h0, 32'h0, 32'h0, "wrap_word0");
`endif

    probe(0, st, dn, r);
    chk("idle_end", 32'(st), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
